// File: rtl/wb_stage.sv
// Writeback stage: owns the MEM/WB register, waits on variable-latency load
// returns, extracts and extends load lanes, and aborts loads that never return.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// IDLE     | accepting instructions; ALU results written the next cycle
// WAIT_MEM | load captured, waiting for mem_rvalid or the timeout count
module wb_stage #(
    parameter int TIMEOUT = 255,
    parameter int TO_W    = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_regwrite,
    input  logic [4:0]  in_rd,
    input  logic [31:0] in_alu_result,
    input  logic        in_is_load,
    input  logic [1:0]  in_load_size,
    input  logic        in_load_unsigned,
    input  logic [1:0]  in_addr_lo,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic        regwrite,
    output logic [4:0]  wb_reg,
    output logic [31:0] wb_data,
    output logic        busy,
    output logic        load_timeout
);

    typedef enum logic {IDLE, WAIT_MEM} state_t;

    state_t          state, state_next;
    logic [TO_W-1:0] cnt, cnt_next;

    logic            cap_regwrite;
    logic [4:0]      cap_rd;
    logic [1:0]      cap_size;
    logic            cap_unsigned;
    logic [1:0]      cap_addr_lo;

    logic            accept;
    logic            capture;
    logic            wr_en;
    logic [4:0]      wr_rd;
    logic [31:0]     wr_data;
    logic            to_en;

    logic [7:0]      lane_b;
    logic [15:0]     lane_h;
    logic [31:0]     load_val;

    assign in_ready = (state == IDLE);
    assign accept   = in_valid && in_ready;

    always_comb begin
        lane_b   = 8'h00;
        lane_h   = 16'h0000;
        load_val = mem_rdata;
        case (cap_addr_lo)
            2'd0:    lane_b = mem_rdata[7:0];
            2'd1:    lane_b = mem_rdata[15:8];
            2'd2:    lane_b = mem_rdata[23:16];
            default: lane_b = mem_rdata[31:24];
        endcase
        lane_h = cap_addr_lo[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (cap_size)
            2'b00:   load_val = {{24{~cap_unsigned & lane_b[7]}}, lane_b};
            2'b01:   load_val = {{16{~cap_unsigned & lane_h[15]}}, lane_h};
            default: load_val = mem_rdata;
        endcase
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        capture    = 1'b0;
        wr_en      = 1'b0;
        wr_rd      = in_rd;
        wr_data    = in_alu_result;
        to_en      = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (in_is_load) begin
                        capture    = 1'b1;
                        cnt_next   = '0;
                        state_next = WAIT_MEM;
                    end else begin
                        wr_en   = in_regwrite && (in_rd != 5'd0);
                        wr_rd   = in_rd;
                        wr_data = in_alu_result;
                    end
                end
            end
            WAIT_MEM: begin
                // Data arriving on the terminal-count cycle still completes the load.
                if (mem_rvalid) begin
                    wr_en      = cap_regwrite && (cap_rd != 5'd0);
                    wr_rd      = cap_rd;
                    wr_data    = load_val;
                    state_next = IDLE;
                end else if (cnt == TO_W'(TIMEOUT)) begin
                    to_en      = 1'b1;
                    state_next = IDLE;
                end else begin
                    cnt_next = cnt + TO_W'(1);
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            cnt          <= '0;
            cap_regwrite <= 1'b0;
            cap_rd       <= 5'd0;
            cap_size     <= 2'b00;
            cap_unsigned <= 1'b0;
            cap_addr_lo  <= 2'b00;
            regwrite     <= 1'b0;
            wb_reg       <= 5'd0;
            wb_data      <= 32'd0;
            busy         <= 1'b0;
            load_timeout <= 1'b0;
        end else begin
            state        <= state_next;
            cnt          <= cnt_next;
            regwrite     <= wr_en;
            load_timeout <= to_en;
            busy         <= (state_next == WAIT_MEM);
            if (capture) begin
                cap_regwrite <= in_regwrite;
                cap_rd       <= in_rd;
                cap_size     <= in_load_size;
                cap_unsigned <= in_load_unsigned;
                cap_addr_lo  <= in_addr_lo;
            end
            // Write address/data only move on a real write so the forwarding
            // unit sees stable values otherwise.
            if (wr_en) begin
                wb_reg  <= wr_rd;
                wb_data <= wr_data;
            end
        end
    end

endmodule

// File: tb/tb_wb_stage.sv
// Bench for wb_stage: directed cases plus random ALU/load traffic, checked by a
// scoreboard of expected write/timeout events against a behavioural model.
module tb_wb_stage;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        in_regwrite = 1'b0;
    logic [4:0]  in_rd = 5'd0;
    logic [31:0] in_alu_result = 32'd0;
    logic        in_is_load = 1'b0;
    logic [1:0]  in_load_size = 2'b00;
    logic        in_load_unsigned = 1'b0;
    logic [1:0]  in_addr_lo = 2'b00;
    logic        mem_rvalid = 1'b0;
    logic [31:0] mem_rdata = 32'd0;
    logic        regwrite;
    logic [4:0]  wb_reg;
    logic [31:0] wb_data;
    logic        busy;
    logic        load_timeout;

    wb_stage #(.TIMEOUT(TO), .TO_W(8)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_regwrite(in_regwrite), .in_rd(in_rd), .in_alu_result(in_alu_result),
        .in_is_load(in_is_load), .in_load_size(in_load_size),
        .in_load_unsigned(in_load_unsigned), .in_addr_lo(in_addr_lo),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .regwrite(regwrite),
        .wb_reg(wb_reg), .wb_data(wb_data), .busy(busy), .load_timeout(load_timeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          is_to;
        logic [4:0]  rd;
        logic [31:0] data;
        int          cyc;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h expected=0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_load(input logic [1:0] size, input bit uns,
                                               input logic [1:0] addr, input logic [31:0] rd_word);
        logic [31:0] v;
        if (size == 2'b00) begin
            v = (rd_word >> (8 * addr)) & 32'hFF;
            if (!uns && v >= 32'h80) v = v - 32'h100;
        end else if (size == 2'b01) begin
            v = (rd_word >> (addr >= 2 ? 16 : 0)) & 32'hFFFF;
            if (!uns && v >= 32'h8000) v = v - 32'h10000;
        end else begin
            v = rd_word;
        end
        return v;
    endfunction

    always @(negedge clk) begin
        if (!reset && (regwrite || load_timeout)) begin
            if (q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL spurious_event regwrite=%0b load_timeout=%0b wb_reg=%0d cyc=%0d",
                         regwrite, load_timeout, wb_reg, cyc);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("event_cycle", cyc, e.cyc);
                chk("load_timeout", {31'd0, load_timeout}, {31'd0, e.is_to});
                chk("regwrite", {31'd0, regwrite}, {31'd0, !e.is_to});
                if (!e.is_to) begin
                    chk("wb_reg", {27'd0, wb_reg}, {27'd0, e.rd});
                    chk("wb_data", wb_data, e.data);
                end
            end
        end
    end

    task automatic issue_alu(input bit rw, input logic [4:0] rd, input logic [31:0] data);
        in_valid = 1'b1; in_is_load = 1'b0; in_regwrite = rw; in_rd = rd; in_alu_result = data;
        @(posedge clk); #1;
        in_valid = 1'b0;
        if (rw && rd != 0) q.push_back('{is_to: 1'b0, rd: rd, data: data, cyc: cyc});
    endtask

    // delay > TO means memory never answers; a stray rvalid then follows.
    task automatic issue_load(input bit rw, input logic [4:0] rd, input logic [1:0] size,
                              input bit uns, input logic [1:0] addr,
                              input logic [31:0] word, input int delay);
        in_valid = 1'b1; in_is_load = 1'b1; in_regwrite = rw; in_rd = rd;
        in_load_size = size; in_load_unsigned = uns; in_addr_lo = addr;
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_rd = 5'($urandom); in_addr_lo = 2'($urandom); in_load_size = 2'($urandom);
        chk("busy_in_wait", {31'd0, busy}, 32'd1);
        chk("in_ready_in_wait", {31'd0, in_ready}, 32'd0);
        if (delay <= TO) begin
            repeat (delay) begin
                mem_rdata = $urandom;
                @(posedge clk); #1;
            end
            mem_rvalid = 1'b1; mem_rdata = word;
            if (rw && rd != 0)
                q.push_back('{is_to: 1'b0, rd: rd, data: model_load(size, uns, addr, word), cyc: cyc + 1});
            @(posedge clk); #1;
            mem_rvalid = 1'b0;
        end else begin
            q.push_back('{is_to: 1'b1, rd: 5'd0, data: 32'd0, cyc: cyc + TO + 1});
            repeat (TO + 1) @(posedge clk);
            #1;
            chk("in_ready_after_timeout", {31'd0, in_ready}, 32'd1);
            mem_rvalid = 1'b1; mem_rdata = $urandom;
            @(posedge clk); #1;
            mem_rvalid = 1'b0;
        end
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        #1;
        chk("reset_regwrite", {31'd0, regwrite}, 32'd0);
        chk("reset_wb_reg", {27'd0, wb_reg}, 32'd0);
        chk("reset_wb_data", wb_data, 32'd0);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_in_ready", {31'd0, in_ready}, 32'd1);

        // Reset while a load to x5 is pending: it must be dropped.
        @(negedge clk);
        in_valid = 1'b1; in_is_load = 1'b1; in_regwrite = 1'b1; in_rd = 5'd5;
        in_load_size = 2'b10;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        #1;
        chk("midload_reset_busy", {31'd0, busy}, 32'd0);
        chk("midload_reset_in_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk); #1 reset = 1'b0;
        mem_rvalid = 1'b1; mem_rdata = 32'hDEADBEEF;
        @(posedge clk); #1;
        mem_rvalid = 1'b0;
        chk("post_reset_regwrite", {31'd0, regwrite}, 32'd0);
        chk("post_reset_wb_reg", {27'd0, wb_reg}, 32'd0);
        chk("post_reset_wb_data", wb_data, 32'd0);
        chk("post_reset_in_ready", {31'd0, in_ready}, 32'd1);

        issue_alu(1'b1, 5'd3, 32'h11);
        issue_alu(1'b1, 5'd4, 32'h22);
        issue_alu(1'b1, 5'd0, 32'h33);
        issue_alu(1'b0, 5'd9, 32'h44);
        issue_load(1'b1, 5'd7, 2'b00, 1'b0, 2'd2, 32'h12803456, 3);
        issue_load(1'b1, 5'd8, 2'b01, 1'b0, 2'd2, 32'h80017FFF, 1);
        issue_load(1'b1, 5'd9, 2'b01, 1'b1, 2'd2, 32'h80017FFF, 0);
        issue_load(1'b1, 5'd10, 2'b10, 1'b0, 2'd3, 32'hA5C3_0F81, 2);
        issue_load(1'b1, 5'd11, 2'b00, 1'b0, 2'd1, 32'h0000_0000, TO + 1);
        issue_load(1'b1, 5'd12, 2'b00, 1'b1, 2'd3, 32'hF000_0000, TO);
        issue_load(1'b1, 5'd0, 2'b10, 1'b0, 2'd0, 32'h1234_5678, 1);

        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 1) == 0)
                issue_alu(1'($urandom), 5'($urandom), $urandom);
            else
                issue_load(1'($urandom), 5'($urandom), 2'($urandom), 1'($urandom),
                           2'($urandom), $urandom, int'($urandom_range(0, TO + 2)));
        end

        repeat (4) @(posedge clk);
        #1;
        chk("scoreboard_drained", q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
